// File: rtl/isqrt_pkg.sv
// Shared types and constants for the iterative integer square root engine.
// ISQRT_LATENCY follows the ISQRT_FSM_TWO_ITER_EN build option and gives the
// cycle count from accepted x_vld to y_vld.
package isqrt_pkg;

   localparam int unsigned ISQRT_X_WIDTH = 32;

`ifdef ISQRT_FSM_TWO_ITER_EN
   localparam int unsigned ISQRT_LATENCY = ISQRT_X_WIDTH / 4 + 1;
`else
   localparam int unsigned ISQRT_LATENCY = ISQRT_X_WIDTH / 2 + 1;
`endif

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_work = 2'd1,
      st_done = 2'd2
   } state_t;

endpackage : isqrt_pkg

// File: rtl/isqrt_step.sv
// One combinational bit-pair iteration of the restoring square root.
// Ports: rem_i/root_i/one_i - current iteration state
//        rem_o/root_o/one_o - state after this iteration
module isqrt_step #(
   parameter int unsigned X_WIDTH = 32
) (
   input  logic [X_WIDTH-1:0] rem_i,
   input  logic [X_WIDTH-1:0] root_i,
   input  logic [X_WIDTH-1:0] one_i,
   output logic [X_WIDTH-1:0] rem_o,
   output logic [X_WIDTH-1:0] root_o,
   output logic [X_WIDTH-1:0] one_o
);

   logic [X_WIDTH-1:0] trial;

   // root + one never overflows X_WIDTH, so no carry bit is kept
   assign trial = root_i + one_i;

   always_comb begin
      rem_o  = rem_i;
      root_o = root_i >> 1;
      if (rem_i >= trial) begin
         rem_o  = rem_i - trial;
         root_o = (root_i >> 1) + one_i;
      end
      one_o = one_i >> 2;
   end

endmodule : isqrt_step

// File: rtl/isqrt_fsm.sv
// Iterative integer square root: y = floor(sqrt(x)) with fixed latency.
// Build option: ISQRT_FSM_TWO_ITER_EN chains two iterations per cycle,
// halving the number of work cycles.
// Ports: clk   - clock, rising edge
//        rst   - synchronous active-high reset
//        x_vld - one-cycle argument strobe, honoured in st_idle/st_done
//        x     - unsigned argument
//        y_vld - one-cycle result strobe
//        y     - result, held until the next result
module isqrt_fsm
   import isqrt_pkg::*;
#(
   parameter  int unsigned X_WIDTH = ISQRT_X_WIDTH,
   localparam int unsigned Y_WIDTH = X_WIDTH / 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x_vld,
   input  logic [X_WIDTH-1:0] x,
   output logic               y_vld,
   output logic [Y_WIDTH-1:0] y
);

`ifdef ISQRT_FSM_TWO_ITER_EN
   localparam int unsigned ITERS = Y_WIDTH / 2;
`else
   localparam int unsigned ITERS = Y_WIDTH;
`endif
   localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [X_WIDTH-1:0] ONE_INIT = X_WIDTH'(1) << (X_WIDTH - 2);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ITERS - 1);

   state_t             state_q, state_d;
   logic [X_WIDTH-1:0] rem_q, rem_d;
   logic [X_WIDTH-1:0] root_q, root_d;
   logic [X_WIDTH-1:0] one_q, one_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [Y_WIDTH-1:0] y_q, y_d;
   logic               y_vld_q, y_vld_d;

   logic [X_WIDTH-1:0] rem_s0, root_s0, one_s0;
   logic [X_WIDTH-1:0] rem_nxt, root_nxt, one_nxt;

   isqrt_step #(.X_WIDTH(X_WIDTH)) u_step0 (
      .rem_i  (rem_q),
      .root_i (root_q),
      .one_i  (one_q),
      .rem_o  (rem_s0),
      .root_o (root_s0),
      .one_o  (one_s0)
   );

`ifdef ISQRT_FSM_TWO_ITER_EN
   isqrt_step #(.X_WIDTH(X_WIDTH)) u_step1 (
      .rem_i  (rem_s0),
      .root_i (root_s0),
      .one_i  (one_s0),
      .rem_o  (rem_nxt),
      .root_o (root_nxt),
      .one_o  (one_nxt)
   );
`else
   assign rem_nxt  = rem_s0;
   assign root_nxt = root_s0;
   assign one_nxt  = one_s0;
`endif

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      root_d  = root_q;
      one_d   = one_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      y_vld_d = 1'b0;

      case (state_q)
         st_idle: begin
            if (x_vld) begin
               rem_d   = x;
               root_d  = '0;
               one_d   = ONE_INIT;
               cnt_d   = '0;
               state_d = st_work;
            end
         end
         st_work: begin
            // x_vld is ignored here; the caller never issues during work
            rem_d  = rem_nxt;
            root_d = root_nxt;
            one_d  = one_nxt;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               y_d     = root_nxt[Y_WIDTH-1:0];
               y_vld_d = 1'b1;
               cnt_d   = '0;
               state_d = st_done;
            end
         end
         st_done: begin
            // Accepting here gives back-to-back results with no idle gap
            if (x_vld) begin
               rem_d   = x;
               root_d  = '0;
               one_d   = ONE_INIT;
               cnt_d   = '0;
               state_d = st_work;
            end else begin
               state_d = st_idle;
            end
         end
         default: state_d = st_idle;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= st_idle;
         rem_q   <= '0;
         root_q  <= '0;
         one_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         y_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         one_q   <= one_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
      end
   end

   assign y_vld = y_vld_q;
   assign y     = y_q;

endmodule : isqrt_fsm

// File: tb/tb_isqrt_fsm.sv
// Scoreboard bench for isqrt_fsm: two instances, directed vectors.
module tb_isqrt_fsm;

`ifdef ISQRT_FSM_TWO_ITER_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 17;
`endif

   typedef struct {
      logic [15:0] y;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_vld_a, x_vld_b;
   logic [31:0] x_a, x_b;
   logic        y_vld_a, y_vld_b;
   logic [15:0] y_a, y_b;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   exp_t qa[$];
   exp_t qb[$];

   isqrt_fsm u_a (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld_a),
      .x     (x_a),
      .y_vld (y_vld_a),
      .y     (y_a)
   );

   isqrt_fsm u_b (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld_b),
      .x     (x_b),
      .y_vld (y_vld_b),
      .y     (y_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every y_vld pulse must match the head of its queue in value and cycle
   always @(negedge clk) begin
      if (y_vld_a === 1'b1) begin
         compared++;
         if (qa.size() == 0) begin
            mismatched++;
            $display("FAIL spurious_y_vld_a cycle=%0d y=%h, no result expected", cyc, y_a);
         end else begin
            exp_t e;
            e = qa.pop_front();
            if (y_a !== e.y || cyc != e.cyc) begin
               mismatched++;
               $display("FAIL result_a got y=%h at cycle %0d, want y=%h at cycle %0d",
                        y_a, cyc, e.y, e.cyc);
            end
         end
      end
      if (y_vld_b === 1'b1) begin
         compared++;
         if (qb.size() == 0) begin
            mismatched++;
            $display("FAIL spurious_y_vld_b cycle=%0d y=%h, no result expected", cyc, y_b);
         end else begin
            exp_t e;
            e = qb.pop_front();
            if (y_b !== e.y || cyc != e.cyc) begin
               mismatched++;
               $display("FAIL result_b got y=%h at cycle %0d, want y=%h at cycle %0d",
                        y_b, cyc, e.y, e.cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One-cycle argument pulse on instance a; expected result is queued
   task automatic pulse_a(input logic [31:0] xv, input logic [15:0] ev);
      exp_t e;
      e.y   = ev;
      e.cyc = cyc + LAT;
      qa.push_back(e);
      x_vld_a = 1'b1;
      x_a     = xv;
      tick(1);
      x_vld_a = 1'b0;
   endtask

   logic [31:0] vx [13];
   logic [15:0] vy [13];

   initial begin
      vx[0]  = 32'd0;          vy[0]  = 16'd0;
      vx[1]  = 32'd1;          vy[1]  = 16'd1;
      vx[2]  = 32'd3;          vy[2]  = 16'd1;
      vx[3]  = 32'd4;          vy[3]  = 16'd2;
      vx[4]  = 32'd99;         vy[4]  = 16'd9;
      vx[5]  = 32'd100;        vy[5]  = 16'd10;
      vx[6]  = 32'd1000000;    vy[6]  = 16'd1000;
      vx[7]  = 32'hFFFFFFFF;   vy[7]  = 16'hFFFF;
      vx[8]  = 32'hFFFE0001;   vy[8]  = 16'hFFFF;
      vx[9]  = 32'hFFFE0000;   vy[9]  = 16'hFFFE;
      vx[10] = 32'd15;         vy[10] = 16'd3;
      vx[11] = 32'd65536;      vy[11] = 16'd256;
      vx[12] = 32'h40000000;   vy[12] = 16'h8000;

      rst = 1'b1;
      x_vld_a = 1'b0; x_vld_b = 1'b0;
      x_a = '0; x_b = '0;
      tick(3);
      rst = 1'b0;

      check("reset_y_vld_a", {31'd0, y_vld_a}, 32'd0);
      check("reset_y_a", {16'd0, y_a}, 32'd0);
      check("reset_y_vld_b", {31'd0, y_vld_b}, 32'd0);
      check("reset_y_b", {16'd0, y_b}, 32'd0);
      tick(2);

      // Directed vectors, one at a time
      for (int i = 0; i < 13; i++) begin
         pulse_a(vx[i], vy[i]);
         tick(LAT + 2);
      end

      // Result held after the pulse
      check("y_hold", {16'd0, y_a}, 32'h00008000);

      // Back-to-back: second argument issued in the y_vld cycle
      pulse_a(32'd16, 16'd4);
      tick(LAT - 1);
      pulse_a(32'd81, 16'd9);
      tick(LAT + 2);

      // x_vld during work is ignored
      pulse_a(32'd49, 16'd7);
      tick(4);
      x_vld_a = 1'b1;
      x_a = 32'd25;
      tick(1);
      x_vld_a = 1'b0;
      tick(LAT + 4);

      // Reset mid-operation discards the result
      x_vld_a = 1'b1;
      x_a = 32'd200;
      tick(1);
      x_vld_a = 1'b0;
      tick(7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midreset_y_vld", {31'd0, y_vld_a}, 32'd0);
      check("midreset_y", {16'd0, y_a}, 32'd0);
      tick(32);
      pulse_a(32'd144, 16'd12);
      tick(LAT + 2);

      // Two instances in lockstep
      begin
         exp_t ea, eb;
         ea.y = 16'd8; ea.cyc = cyc + LAT;
         eb.y = 16'd3; eb.cyc = cyc + LAT;
         qa.push_back(ea);
         qb.push_back(eb);
         x_vld_a = 1'b1; x_a = 32'd64;
         x_vld_b = 1'b1; x_b = 32'd9;
         tick(1);
         x_vld_a = 1'b0; x_vld_b = 1'b0;
      end

      // Bounded drain of outstanding expectations
      for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) tick(1);
      tick(3);
      check("queue_a_drained", qa.size(), 32'd0);
      check("queue_b_drained", qb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_isqrt_fsm
